// File: rtl/sprite_plotter.sv
// sprite_plotter
//   Sits between the game-control FSM and vga_adapter (160x120, 3-bit colour).
//   Takes one draw or erase request per req/ready handshake. It then writes every
//   pixel of the sprite's bounding box, one pixel per clock, and pulses done when
//   the sprite is finished.
//
// Ports
//   CLOCK_50  in   system clock
//   reset_n   in   synchronous, active-low reset
//   req       in   request valid; sampled only while ready=1
//   item      in   0 = garbage, 1 = press
//   erase     in   1 = paint the whole box black
//   pos       in   slot index: press 0..6 (7 is rejected); garbage uses pos[1:0]
//   ready     out  high in IDLE
//   done      out  one-cycle pulse at the end of every request, including rejected ones
//   err       out  qualifies done: 1 = request was rejected
//   x, y      out  pixel address
//   colour    out  {R,G,B}
//   plot      out  pixel write strobe; x/y/colour are valid while plot=1

module sprite_plotter #(
    parameter int unsigned SLOT_STEP = 20,
    parameter int unsigned PRESS_W   = 40,
    parameter int unsigned PRESS_H   = 60,
    parameter int unsigned PRESS_Y0  = 0,
    parameter int unsigned STEM_W    = 8,
    parameter int unsigned HEAD_H    = 8,
    parameter int unsigned GARB_W    = 20,
    parameter int unsigned GARB_H    = 20,
    parameter int unsigned GARB_XOFF = 10,
    parameter int unsigned GARB_Y0   = 100
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       req,
    input  logic       item,
    input  logic       erase,
    input  logic [2:0] pos,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    // Sprite geometry, pre-sized to the counter and address widths.
    localparam logic [5:0] PressWLast = 6'(PRESS_W - 1);
    localparam logic [5:0] PressHLast = 6'(PRESS_H - 1);
    localparam logic [5:0] GarbWLast  = 6'(GARB_W - 1);
    localparam logic [5:0] GarbHLast  = 6'(GARB_H - 1);
    localparam logic [5:0] StemLo     = 6'((PRESS_W - STEM_W) / 2);
    localparam logic [5:0] StemHi     = 6'((PRESS_W - STEM_W) / 2 + STEM_W - 1);
    localparam logic [5:0] HeadRow    = 6'(PRESS_H - HEAD_H);
    localparam logic [7:0] SlotStep   = 8'(SLOT_STEP);
    localparam logic [7:0] GarbXoff   = 8'(GARB_XOFF);
    localparam logic [6:0] PressY0    = 7'(PRESS_Y0);
    localparam logic [6:0] GarbY0     = 7'(GARB_Y0);

    localparam logic [2:0] ColBlack = 3'b000;
    localparam logic [2:0] ColGreen = 3'b010;
    localparam logic [2:0] ColWhite = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic       item_q, item_d;
    logic       erase_q, erase_d;
    logic       err_q, err_d;
    logic [2:0] pos_q, pos_d;
    logic [5:0] col_q, col_d;
    logic [5:0] row_q, row_d;

    // ------------------------------------------------------------------
    // Pixel datapath (from latched request and counters)
    // ------------------------------------------------------------------
    logic [5:0] w_last, h_last;
    logic [7:0] slot;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic       in_stem, in_head;
    logic [2:0] pix_colour;

    always_comb begin
        w_last = item_q ? PressWLast : GarbWLast;
        h_last = item_q ? PressHLast : GarbHLast;

        // Garbage only has four slots, so it ignores pos[2].
        slot   = item_q ? {5'd0, pos_q} : {6'd0, pos_q[1:0]};
        base_x = item_q ? (slot * SlotStep) : (slot * SlotStep + GarbXoff);
        base_y = item_q ? PressY0 : GarbY0;

        pix_x  = base_x + {2'b00, col_q};
        pix_y  = base_y + {1'b0, row_q};

        in_stem = (col_q >= StemLo) && (col_q <= StemHi);
        in_head = (row_q >= HeadRow);

        // Every box pixel is written, so press draws also scrub stale background.
        if (erase_q) begin
            pix_colour = ColBlack;
        end else if (!item_q) begin
            pix_colour = ColGreen;
        end else if (in_stem || in_head) begin
            pix_colour = ColWhite;
        end else begin
            pix_colour = ColBlack;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        item_d  = item_q;
        erase_d = erase_q;
        err_d   = err_q;
        pos_d   = pos_q;
        col_d   = col_q;
        row_d   = row_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    item_d  = item;
                    erase_d = erase;
                    pos_d   = pos;
                    col_d   = 6'd0;
                    row_d   = 6'd0;
                    // Press slot 7 would run off the right edge of the screen.
                    if (item && (pos == 3'd7)) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StDraw;
                    end
                end
            end

            StDraw: begin
                if (col_q == w_last) begin
                    col_d = 6'd0;
                    if (row_q == h_last) begin
                        state_d = StDone;
                    end else begin
                        row_d = row_q + 6'd1;
                    end
                end else begin
                    col_d = col_q + 6'd1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (Moore: decoded from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        ready  = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        plot   = 1'b0;
        x      = 8'd0;
        y      = 7'd0;
        colour = 3'd0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
            end
            StDraw: begin
                plot   = 1'b1;
                x      = pix_x;
                y      = pix_y;
                colour = pix_colour;
            end
            StDone: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= StIdle;
            item_q  <= 1'b0;
            erase_q <= 1'b0;
            err_q   <= 1'b0;
            pos_q   <= 3'd0;
            col_q   <= 6'd0;
            row_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            item_q  <= item_d;
            erase_q <= erase_d;
            err_q   <= err_d;
            pos_q   <= pos_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

endmodule
